// File: rtl/countdown_timer.sv
// Down-counting timer with one-shot and periodic modes.
// Stop, start and pause act in that order of priority, and the timer strobes underflow_pulse when a period ends.
module countdown_timer #(
   parameter int unsigned bitwidth         = 8,
   parameter int unsigned restart_on_start = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   input  logic                pause,
   input  logic                autoreload,
   input  logic [bitwidth-1:0] load_value,
   output logic [bitwidth-1:0] active_load_value,
   output logic [bitwidth-1:0] value,
   output logic                running,
   output logic                expired,
   output logic                underflow_pulse
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic restart_en = (restart_on_start != 0);
   localparam logic [bitwidth-1:0] one = bitwidth'(1);

   state_t              state, state_next;
   logic                start_q, stop_q;
   logic                start_edge, stop_edge, load_ok;
   logic [bitwidth-1:0] value_next, active_next;
   logic                pulse_next;

   assign start_edge = start & ~start_q;
   assign stop_edge  = stop & ~stop_q;
   assign load_ok    = (load_value != '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         start_q           <= 1'b0;
         stop_q            <= 1'b0;
         value             <= '0;
         active_load_value <= '0;
         underflow_pulse   <= 1'b0;
      end else begin
         state             <= state_next;
         start_q           <= start;
         stop_q            <= stop;
         value             <= value_next;
         active_load_value <= active_next;
         underflow_pulse   <= pulse_next;
      end
   end

   always_comb begin
      state_next  = state;
      value_next  = value;
      active_next = active_load_value;
      pulse_next  = 1'b0;
      case (state)
         IDLE: begin
            if (!stop_edge && start_edge && load_ok) begin
               value_next  = load_value;
               active_next = load_value;
               state_next  = RUN;
            end
         end
         RUN: begin
            if (stop_edge) begin
               value_next = '0;
               state_next = IDLE;
            end else if (start_edge && restart_en && load_ok) begin
               value_next  = load_value;
               active_next = load_value;
            end else if (pause) begin
               state_next = HOLD;
            end else if (value > one) begin
               value_next = value - one;
            end else if (autoreload && load_ok) begin
               // Periodic reload lands on the same edge as the pulse, keeping periods exactly N cycles
               value_next  = load_value;
               active_next = load_value;
               pulse_next  = 1'b1;
            end else begin
               value_next = '0;
               pulse_next = 1'b1;
               state_next = DONE;
            end
         end
         HOLD: begin
            if (stop_edge) begin
               value_next = '0;
               state_next = IDLE;
            end else if (start_edge && restart_en && load_ok) begin
               value_next  = load_value;
               active_next = load_value;
            end else if (!pause) begin
               state_next = RUN;
            end
         end
         DONE: begin
            if (stop_edge) begin
               state_next = IDLE;
            end else if (start_edge && load_ok) begin
               value_next  = load_value;
               active_next = load_value;
               state_next  = RUN;
            end
         end
         default: begin
            value_next = '0;
            state_next = IDLE;
         end
      endcase
   end

   assign running = (state == RUN) || (state == HOLD);
   assign expired = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: two instances (restart_on_start 0 and 1) share stimulus.
// An event-level model is compared on every falling edge; literal checks pin key moments.
module tb_countdown_timer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start, stop, pause, autoreload;
   logic [7:0] load_value;
   logic [7:0] value_o  [2];
   logic [7:0] active_o [2];
   logic       running_o[2];
   logic       expired_o[2];
   logic       pulse_o  [2];

   int tests = 0;
   int failures = 0;

   always #5 clock = ~clock;

   countdown_timer #(.bitwidth(8), .restart_on_start(0)) dut0 (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
      .autoreload(autoreload), .load_value(load_value),
      .active_load_value(active_o[0]), .value(value_o[0]), .running(running_o[0]),
      .expired(expired_o[0]), .underflow_pulse(pulse_o[0])
   );

   countdown_timer #(.bitwidth(8), .restart_on_start(1)) dut1 (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
      .autoreload(autoreload), .load_value(load_value),
      .active_load_value(active_o[1]), .value(value_o[1]), .running(running_o[1]),
      .expired(expired_o[1]), .underflow_pulse(pulse_o[1])
   );

   task automatic check(input string name, input int unsigned actual, input int unsigned expected);
      tests++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic lit(input int i, input string name, input int unsigned v, input int unsigned a,
                      input int unsigned r, input int unsigned e, input int unsigned p);
      check($sformatf("%s_value%0d", name, i),   value_o[i],   v);
      check($sformatf("%s_active%0d", name, i),  active_o[i],  a);
      check($sformatf("%s_running%0d", name, i), running_o[i], r);
      check($sformatf("%s_expired%0d", name, i), expired_o[i], e);
      check($sformatf("%s_pulse%0d", name, i),   pulse_o[i],   p);
   endtask

   // Model: the timer is either busy (counting or held), done, or neither.
   bit          m_ps, m_pt;
   int unsigned m_rem[2], m_per[2];
   bit          m_busy[2], m_held[2], m_done[2], m_pulse[2];

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_ps = 0; m_pt = 0;
         for (int i = 0; i < 2; i++) begin
            m_rem[i] = 0; m_per[i] = 0; m_busy[i] = 0; m_held[i] = 0; m_done[i] = 0; m_pulse[i] = 0;
         end
      end else begin
         bit se, te;
         se = start && !m_ps;
         te = stop && !m_pt;
         for (int i = 0; i < 2; i++) begin
            m_pulse[i] = 0;
            if (te) begin
               m_busy[i] = 0; m_held[i] = 0; m_done[i] = 0; m_rem[i] = 0;
            end else if (se && load_value != 0 && (!m_busy[i] || i == 1)) begin
               if (!m_busy[i]) m_held[i] = 0;
               m_rem[i] = load_value; m_per[i] = load_value; m_busy[i] = 1; m_done[i] = 0;
            end else if (m_busy[i]) begin
               if (m_held[i]) m_held[i] = pause;
               else if (pause) m_held[i] = 1;
               else if (m_rem[i] > 1) m_rem[i] = m_rem[i] - 1;
               else begin
                  m_pulse[i] = 1;
                  if (autoreload && load_value != 0) begin
                     m_rem[i] = load_value; m_per[i] = load_value;
                  end else begin
                     m_rem[i] = 0; m_busy[i] = 0; m_done[i] = 1;
                  end
               end
            end
         end
         m_ps = start;
         m_pt = stop;
      end
   end

   always @(negedge clock) begin
      for (int i = 0; i < 2; i++) begin
         check($sformatf("cmp_value%0d", i),   value_o[i],   m_rem[i]);
         check($sformatf("cmp_active%0d", i),  active_o[i],  m_per[i]);
         check($sformatf("cmp_running%0d", i), running_o[i], m_busy[i]);
         check($sformatf("cmp_expired%0d", i), expired_o[i], m_done[i]);
         check($sformatf("cmp_pulse%0d", i),   pulse_o[i],   m_pulse[i]);
      end
   end

   int npulse;
   int found;

   initial begin
      start = 0; stop = 0; pause = 0; autoreload = 0; load_value = 0;
      reset = 1;
      repeat (2) @(negedge clock);
      for (int i = 0; i < 2; i++) lit(i, "reset", 0, 0, 0, 0, 0);
      reset = 0;
      @(negedge clock);

      // one-shot, period 5
      load_value = 5; start = 1;
      @(negedge clock);
      for (int i = 0; i < 2; i++) lit(i, "oneshot_load", 5, 5, 1, 0, 0);
      for (int k = 4; k >= 0; k--) begin
         @(negedge clock);
         for (int i = 0; i < 2; i++) check($sformatf("oneshot_count%0d_%0d", k, i), value_o[i], k);
      end
      for (int i = 0; i < 2; i++) lit(i, "oneshot_expire", 0, 5, 0, 1, 1);
      @(negedge clock);
      for (int i = 0; i < 2; i++) lit(i, "oneshot_done", 0, 5, 0, 1, 0);
      start = 0;
      @(negedge clock);

      // periodic, period 3, then 6
      load_value = 3; autoreload = 1; start = 1;
      @(negedge clock);
      for (int i = 0; i < 2; i++) lit(i, "periodic_load", 3, 3, 1, 0, 0);
      npulse = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         if (pulse_o[0]) begin
            npulse++;
            check("periodic_spacing", k % 3, 0);
         end
      end
      check("periodic_pulses", npulse, 4);
      load_value = 6;
      @(negedge clock);
      lit(0, "periodic_keep_a", 2, 3, 1, 0, 0);
      @(negedge clock);
      lit(0, "periodic_keep_b", 1, 3, 1, 0, 0);
      @(negedge clock);
      lit(0, "periodic_reload6", 6, 6, 1, 0, 1);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         check($sformatf("period6_pulse_%0d", k), pulse_o[0], (k == 6) ? 1 : 0);
      end
      start = 0; stop = 1;
      @(negedge clock);
      for (int i = 0; i < 2; i++) lit(i, "periodic_stop", 0, 6, 0, 0, 0);
      stop = 0;

      // pause at 7 for four edges
      load_value = 10; autoreload = 0; start = 1;
      @(negedge clock);
      check("pause_load", value_o[0], 10);
      start = 0;
      repeat (3) @(negedge clock);
      check("pause_at7", value_o[0], 7);
      pause = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         check($sformatf("pause_hold_%0d", k), value_o[0], 7);
         check($sformatf("pause_running_%0d", k), running_o[0], 1);
      end
      pause = 0;
      found = 0;
      for (int k = 1; k <= 20 && found == 0; k++) begin
         @(negedge clock);
         if (pulse_o[0]) found = k;
      end
      check("pause_expiry_cycle", found, 8);

      // stop at value 4
      load_value = 6; start = 1;
      @(negedge clock);
      start = 0;
      repeat (2) @(negedge clock);
      check("stop_at4", value_o[0], 4);
      stop = 1;
      @(negedge clock);
      for (int i = 0; i < 2; i++) lit(i, "stop_idle", 0, 6, 0, 0, 0);
      @(negedge clock);
      check("stop_no_pulse", pulse_o[0], 0);
      stop = 0;
      @(negedge clock);

      // simultaneous start and stop edges in IDLE
      start = 1; stop = 1; load_value = 7;
      @(negedge clock);
      for (int i = 0; i < 2; i++) lit(i, "start_stop", 0, 6, 0, 0, 0);
      start = 0; stop = 0;
      @(negedge clock);

      // restart while running
      load_value = 5; start = 1;
      @(negedge clock);
      start = 0;
      repeat (3) @(negedge clock);
      check("restart_pre0", value_o[0], 2);
      check("restart_pre1", value_o[1], 2);
      load_value = 8; start = 1;
      @(negedge clock);
      lit(0, "restart_ignored", 1, 5, 1, 0, 0);
      lit(1, "restart_taken", 8, 8, 1, 0, 0);
      @(negedge clock);
      lit(0, "restart_expire", 0, 5, 0, 1, 1);
      lit(1, "restart_count", 7, 8, 1, 0, 0);
      start = 0; stop = 1;
      @(negedge clock);
      stop = 0;
      @(negedge clock);

      // zero load is ignored
      load_value = 0; start = 1;
      @(negedge clock);
      check("zero_load_run0", running_o[0], 0);
      check("zero_load_run1", running_o[1], 0);
      check("zero_load_value", value_o[0], 0);
      start = 0;
      @(negedge clock);

      // asynchronous reset mid-count, start held across release
      load_value = 20; start = 1;
      @(negedge clock);
      repeat (3) @(negedge clock);
      check("areset_pre", value_o[0], 17);
      load_value = 9;
      #2 reset = 1;
      #1;
      for (int i = 0; i < 2; i++) lit(i, "areset", 0, 0, 0, 0, 0);
      @(negedge clock);
      reset = 0;
      @(negedge clock);
      for (int i = 0; i < 2; i++) lit(i, "areset_restart", 9, 9, 1, 0, 0);
      start = 0;
      repeat (2) @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
